// File: rtl/evg_hardware_trigger_decoder.sv
// EVG hardware trigger decoder: consumes the event-code stream and drives per-channel
// programmable-width trigger pulses. Define EVG_HWTRIG_DELAY_EN for per-channel trigger delay.
module evg_hardware_trigger_decoder #(
    parameter int unsigned HARDWARE_TRIGGER_COUNT = 8,
    parameter int unsigned EVENTCODE_WIDTH        = 8,
    parameter int unsigned PULSE_WIDTH_WIDTH      = 8
) (
    input  logic                              evgTxClk,
    input  logic                              evgTxRst,
    input  logic                              sysCSRstrobe,
    input  logic [31:0]                       sysGPIO_OUT,
    output logic [31:0]                       status,
    input  logic [EVENTCODE_WIDTH-1:0]        evgEventTDATA,
    input  logic                              evgEventTVALID,
    output logic                              evgEventTREADY,
    output logic [HARDWARE_TRIGGER_COUNT-1:0] hwTriggers
);

    localparam int unsigned CH_N = HARDWARE_TRIGGER_COUNT;
    localparam int unsigned EW   = EVENTCODE_WIDTH;
    localparam int unsigned PW   = PULSE_WIDTH_WIDTH;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    logic [EW-1:0]   code_q  [CH_N];
    logic [EW-1:0]   code_d  [CH_N];
    logic [PW-1:0]   width_q [CH_N];
    logic [PW-1:0]   width_d [CH_N];
    logic [PW-1:0]   cnt_q   [CH_N];
    logic [PW-1:0]   cnt_d   [CH_N];
    logic [AW-1:0]   rbk_q, rbk_d;
    logic            ev_vld_q, ev_vld_d;
    logic [EW-1:0]   ev_code_q, ev_code_d;
    logic            tready_q, tready_d;
    logic [CH_N-1:0] hw_q, hw_d;
    logic [31:0]     status_q, status_d;

    logic            wr_en;
    logic [AW-1:0]   wr_ch;
    logic [CH_N-1:0] match;
    logic            unused_gpio;

`ifdef EVG_HWTRIG_DELAY_EN
    logic [DW-1:0]   delay_q  [CH_N];
    logic [DW-1:0]   delay_d  [CH_N];
    logic [DW-1:0]   dcnt_q   [CH_N];
    logic [DW-1:0]   dcnt_d   [CH_N];
    logic [PW-1:0]   pend_w_q [CH_N];
    logic [PW-1:0]   pend_w_d [CH_N];
    logic            dly_wr;
`endif

    assign unused_gpio = ^{sysGPIO_OUT[29:24], sysGPIO_OUT[15:11]};

    // Width 0 is treated as a single-cycle pulse.
    function automatic logic [PW-1:0] pulse_len(input logic [PW-1:0] w);
        return (w == '0) ? PW'(1) : w;
    endfunction

    // Register file, event capture, code compare and pulse/delay counters.
    always_comb begin
        code_d    = code_q;
        width_d   = width_q;
        cnt_d     = cnt_q;
        rbk_d     = rbk_q;
        hw_d      = '0;
        match     = '0;
        tready_d  = 1'b1;
        ev_vld_d  = evgEventTVALID && tready_q;
        ev_code_d = evgEventTVALID ? evgEventTDATA : ev_code_q;
        wr_en     = sysCSRstrobe && sysGPIO_OUT[31] && !sysGPIO_OUT[30];
        wr_ch     = sysGPIO_OUT[10:8];
`ifdef EVG_HWTRIG_DELAY_EN
        delay_d   = delay_q;
        dcnt_d    = dcnt_q;
        pend_w_d  = pend_w_q;
        dly_wr    = sysCSRstrobe && sysGPIO_OUT[31] && sysGPIO_OUT[30];
`endif

        if (wr_en) begin
            code_d[wr_ch]  = EW'(sysGPIO_OUT[7:0]);
            width_d[wr_ch] = PW'(sysGPIO_OUT[23:16]);
        end
`ifdef EVG_HWTRIG_DELAY_EN
        if (dly_wr) begin
            delay_d[wr_ch] = DW'(sysGPIO_OUT[7:0]);
        end
`endif
        if (sysCSRstrobe) begin
            rbk_d = sysGPIO_OUT[10:8];
        end

        for (int ch = 0; ch < CH_N; ch++) begin
            // Event code zero is reserved and never fires; a zero-coded channel is thereby disabled.
            match[ch] = ev_vld_q && (ev_code_q != '0) && (code_q[ch] == ev_code_q);

            if (cnt_q[ch] != '0) begin
                cnt_d[ch] = cnt_q[ch] - PW'(1);
            end
`ifdef EVG_HWTRIG_DELAY_EN
            if (dcnt_q[ch] != '0) begin
                dcnt_d[ch] = dcnt_q[ch] - DW'(1);
            end
            if (dcnt_q[ch] == DW'(1)) begin
                cnt_d[ch] = pend_w_q[ch];
            end
            // A match while a delayed pulse is pending is dropped.
            if (match[ch] && (dcnt_q[ch] == '0)) begin
                if (delay_q[ch] == '0) begin
                    cnt_d[ch] = pulse_len(width_q[ch]);
                end else begin
                    dcnt_d[ch]   = delay_q[ch];
                    pend_w_d[ch] = pulse_len(width_q[ch]);
                end
            end
`else
            if (match[ch]) begin
                cnt_d[ch] = pulse_len(width_q[ch]);
            end
`endif
            hw_d[ch] = (cnt_d[ch] != '0);
        end

        status_d            = '0;
        status_d[EW-1:0]    = code_q[rbk_q];
        status_d[8 +: AW]   = rbk_q;
        status_d[16 +: CH_N] = hw_q;
`ifdef EVG_HWTRIG_DELAY_EN
        status_d[24 +: DW]  = delay_q[rbk_q];
`endif
    end

    always_ff @(posedge evgTxClk) begin
        if (evgTxRst) begin
            for (int i = 0; i < CH_N; i++) begin
                code_q[i]   <= '0;
                width_q[i]  <= '0;
                cnt_q[i]    <= '0;
`ifdef EVG_HWTRIG_DELAY_EN
                delay_q[i]  <= '0;
                dcnt_q[i]   <= '0;
                pend_w_q[i] <= '0;
`endif
            end
            rbk_q     <= '0;
            ev_vld_q  <= 1'b0;
            ev_code_q <= '0;
            tready_q  <= 1'b0;
            hw_q      <= '0;
            status_q  <= '0;
        end else begin
            code_q    <= code_d;
            width_q   <= width_d;
            cnt_q     <= cnt_d;
`ifdef EVG_HWTRIG_DELAY_EN
            delay_q   <= delay_d;
            dcnt_q    <= dcnt_d;
            pend_w_q  <= pend_w_d;
`endif
            rbk_q     <= rbk_d;
            ev_vld_q  <= ev_vld_d;
            ev_code_q <= ev_code_d;
            tready_q  <= tready_d;
            hw_q      <= hw_d;
            status_q  <= status_d;
        end
    end

    assign status         = status_q;
    assign hwTriggers     = hw_q;
    assign evgEventTREADY = tready_q;

endmodule

// File: tb/tb_evg_hardware_trigger_decoder.sv
// Bench for evg_hardware_trigger_decoder: directed scenarios plus randomized traffic
// checked every cycle against an interval-based reference model.
module tb_evg_hardware_trigger_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic [31:0] gpio;
    logic [31:0] status;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic [7:0]  hw;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    evg_hardware_trigger_decoder dut (
        .evgTxClk       (clk),
        .evgTxRst       (rst),
        .sysCSRstrobe   (strobe),
        .sysGPIO_OUT    (gpio),
        .status         (status),
        .evgEventTDATA  (tdata),
        .evgEventTVALID (tvalid),
        .evgEventTREADY (tready),
        .hwTriggers     (hw)
    );

    // Reference model: each channel is high on every edge index up to m_end.
    logic [7:0]  m_code  [8];
    logic [7:0]  m_width [8];
    logic [7:0]  m_dly   [8];
    logic [2:0]  m_rbk;
    int          m_end   [8];
    int          m_pend  [8];
    int          m_pw    [8];
    bit          m_acc;
    logic [7:0]  m_acc_code;
    logic        m_tready;
    logic [31:0] m_status;
    logic [7:0]  m_hw;
    int          edge_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [31:0] g,
                              input logic v, input logic [7:0] d);
        int w;
        logic [7:0] dly_rb;
        edge_n++;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_code[i] = 8'h00; m_width[i] = 8'h00; m_dly[i] = 8'h00;
                m_end[i] = -1; m_pend[i] = -1; m_pw[i] = 0;
            end
            m_rbk = 3'd0; m_acc = 1'b0; m_acc_code = 8'h00;
            m_tready = 1'b0; m_status = 32'h0; m_hw = 8'h00;
        end else begin
`ifdef EVG_HWTRIG_DELAY_EN
            dly_rb = m_dly[m_rbk];
`else
            dly_rb = 8'h00;
`endif
            m_status = {dly_rb, m_hw, 5'b0, m_rbk, m_code[m_rbk]};
            if (m_acc && m_acc_code != 8'h00) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_code[i] == m_acc_code) begin
                        w = (m_width[i] == 8'h00) ? 1 : int'(m_width[i]);
`ifdef EVG_HWTRIG_DELAY_EN
                        if (m_pend[i] >= edge_n) begin
                            w = w;
                        end else if (m_dly[i] == 8'h00) begin
                            m_end[i] = edge_n - 1 + w;
                        end else begin
                            m_pend[i] = edge_n + int'(m_dly[i]);
                            m_pw[i] = w;
                        end
`else
                        m_end[i] = edge_n - 1 + w;
`endif
                    end
                end
            end
`ifdef EVG_HWTRIG_DELAY_EN
            for (int i = 0; i < 8; i++)
                if (m_pend[i] == edge_n) m_end[i] = edge_n - 1 + m_pw[i];
`endif
            if (s) begin
                if (g[31] && !g[30]) begin
                    m_code[g[10:8]] = g[7:0];
                    m_width[g[10:8]] = g[23:16];
                end
`ifdef EVG_HWTRIG_DELAY_EN
                if (g[31] && g[30]) m_dly[g[10:8]] = g[7:0];
`endif
                m_rbk = g[10:8];
            end
            m_acc = v && m_tready;
            m_acc_code = d;
            m_tready = 1'b1;
            for (int i = 0; i < 8; i++) m_hw[i] = (edge_n <= m_end[i]);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hwTriggers", 32'(hw), 32'(m_hw));
            chk("TREADY", 32'(tready), 32'(m_tready));
            chk("status", status, m_status);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic [31:0] g,
                       input logic v, input logic [7:0] d);
        rst = r; strobe = s; gpio = g; tvalid = v; tdata = d;
        @(posedge clk);
        model_edge(r, s, g, v, d);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic ev(input logic [7:0] c);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, c);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] c, input logic [7:0] w);
        cyc(1'b0, 1'b1, {2'b10, 6'b0, w, 5'b0, ch, c}, 1'b0, 8'h00);
    endtask

    int ones, rises, prev;
    logic [7:0]  acc;
    logic [15:0] mask;
    logic [15:0] exp_mask;

    task automatic samp1();
        if (hw[1]) ones++;
        if (hw[1] && prev == 0) rises++;
        prev = int'(hw[1]);
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; gpio = 32'h0; tvalid = 1'b0; tdata = 8'h00;
        @(negedge clk);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
        chk("reset_hw", 32'(hw), 32'h0);
        chk("reset_tready", 32'(tready), 32'h0);
        chk("reset_status", status, 32'h0);

        // Single-cycle pulse on ch3.
        cyc(1'b0, 1'b1, 32'h8000_0321, 1'b0, 8'h00);
        chk("tready_after_reset", 32'(tready), 32'h1);
        ev(8'h21);
        chk("ch3_n1", 32'(hw), 32'h00);
        idle();
        chk("ch3_n2", 32'(hw), 32'h08);
        idle();
        chk("ch3_n3", 32'(hw), 32'h00);
        chk("tready_steady", 32'(tready), 32'h1);

        // Shared code on ch0 and ch5, width 4.
        wr(3'd0, 8'h40, 8'd4);
        wr(3'd5, 8'h40, 8'd4);
        ev(8'h40);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("dual_high", 32'(hw), 32'h21);
        end
        idle();
        chk("dual_low", 32'(hw), 32'h00);

        // Retrigger ch1 (width 10) at N and N+5.
        wr(3'd1, 8'h11, 8'd10);
        ones = 0; rises = 0; prev = 0;
        ev(8'h11); samp1();
        repeat (4) begin idle(); samp1(); end
        ev(8'h11); samp1();
        repeat (20) begin idle(); samp1(); end
        chk("retrig_len", 32'(ones), 32'd15);
        chk("retrig_rises", 32'(rises), 32'd1);

        // All codes zero: no event may fire.
        for (int c = 0; c < 8; c++) wr(3'(c), 8'h00, 8'h00);
        acc = 8'h00;
        for (int c = 0; c < 256; c++) begin
            ev(8'(c));
            acc |= hw;
        end
        repeat (3) begin idle(); acc |= hw; end
        chk("zero_code_quiet", 32'(acc), 32'h0);
        wr(3'd7, 8'hFF, 8'h00);
        cyc(1'b0, 1'b1, 32'h0000_0700, 1'b0, 8'h00);
        idle();
        chk("rbk_code", 32'(status[7:0]), 32'hFF);
        chk("rbk_addr", 32'(status[10:8]), 32'h7);

        // Reset during a long pulse.
        wr(3'd2, 8'h55, 8'd200);
        ev(8'h55);
        repeat (10) idle();
        chk("long_pulse_on", 32'(hw), 32'h04);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
        chk("rst_mid_hw", 32'(hw), 32'h0);
        chk("rst_mid_tready", 32'(tready), 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 32'h0000_0200, 1'b0, 8'h00);
        idle();
        chk("rst_table_clear", status, 32'h0000_0200);
        ev(8'h55);
        acc = 8'h00;
        repeat (4) begin idle(); acc |= hw; end
        chk("rst_old_code_dead", 32'(acc), 32'h0);

        // Delay feature scenario: events at N and N+3.
        cyc(1'b0, 1'b1, 32'h8002_0222, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 32'hC000_0205, 1'b0, 8'h00);
        mask = 16'h0;
        ev(8'h22);  mask[1] = hw[2];
        idle();     mask[2] = hw[2];
        idle();     mask[3] = hw[2];
        ev(8'h22);  mask[4] = hw[2];
        for (int j = 5; j < 16; j++) begin
            idle();
            mask[j] = hw[2];
        end
`ifdef EVG_HWTRIG_DELAY_EN
        exp_mask = 16'h0180;
`else
        exp_mask = 16'h006C;
`endif
        chk("delay_mask", 32'(mask), 32'(exp_mask));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic r, s, v;
            logic [31:0] g;
            logic [7:0] d;
            r = ($urandom_range(399) == 0);
            s = ($urandom_range(9) == 0);
            g = $urandom();
            g[31] = ($urandom_range(3) != 0);
            g[30] = ($urandom_range(3) == 0);
            g[7:0] = g[30] ? 8'($urandom_range(8)) : 8'($urandom_range(6));
            g[23:16] = ($urandom_range(15) == 0) ? 8'($urandom()) : 8'($urandom_range(12));
            v = !(s && g[31]) && ($urandom_range(1) == 0);
            d = ($urandom_range(7) == 0) ? 8'($urandom()) : 8'($urandom_range(6));
            cyc(r, s, g, v, d);
        end
        repeat (300) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
